// File: rtl/sccomp_dbg_pkg.sv
// Shared types for the sccomp run/halt/debug sequencer: state encoding,
// stop-cause codes and the register-file index width.
package sccomp_dbg_pkg;

    localparam int RF_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DUMP_SEL,
        ST_DUMP_OUT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_PC   = 2'd1,
        CAUSE_HALT = 2'd2,
        CAUSE_TMO  = 2'd3
    } cause_t;

endpackage

// File: rtl/sccomp_run_ctrl_if.sv
// Register-dump stream: one beat per register, valid/ready handshake.
interface sccomp_run_ctrl_if #(
    parameter int DATA_W = 32
);
    import sccomp_dbg_pkg::*;

    logic                dump_valid;
    logic                dump_ready;
    logic [RF_IDX_W-1:0] dump_idx;
    logic [DATA_W-1:0]   dump_data;
    logic                dump_last;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/sccomp_reg_dumper.sv
// Walks the register-file debug port and emits every register as one
// stream beat; two cycles per register when the consumer never stalls.
module sccomp_reg_dumper
    import sccomp_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                beat_ack,
    output logic                done,
    output logic [RF_IDX_W-1:0] reg_sel,
    input  logic [DATA_W-1:0]   reg_data,
    sccomp_run_ctrl_if.master   dump
);

    localparam logic [RF_IDX_W-1:0] LAST_IDX = RF_IDX_W'(NREG - 1);

    state_t phase_reg;

    assign beat_ack = (phase_reg == ST_DUMP_OUT) && dump.dump_ready;
    assign done     = beat_ack && dump.dump_last;

    // reg_sel doubles as the walk index, so it already points at the
    // register being captured during the select phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_reg       <= ST_IDLE;
            reg_sel         <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_idx   <= '0;
            dump.dump_data  <= '0;
            dump.dump_last  <= 1'b0;
        end else begin
            case (phase_reg)
                ST_DUMP_SEL: begin
                    dump.dump_data  <= (reg_sel == '0) ? '0 : reg_data;
                    dump.dump_idx   <= reg_sel;
                    dump.dump_last  <= (reg_sel == LAST_IDX);
                    dump.dump_valid <= 1'b1;
                    phase_reg       <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (dump.dump_ready) begin
                        dump.dump_valid <= 1'b0;
                        if (dump.dump_last) begin
                            phase_reg <= ST_IDLE;
                        end else begin
                            reg_sel   <= reg_sel + 1'b1;
                            phase_reg <= ST_DUMP_SEL;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        reg_sel   <= '0;
                        phase_reg <= ST_DUMP_SEL;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sccomp_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle CPU: gates execution with a
// clock-enable, stops on breakpoint/halt/budget, then dumps the register file.
module sccomp_run_ctrl
    import sccomp_dbg_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                step,
    input  logic                halt_req,
    input  logic                stop_pc_en,
    input  logic [PC_W-1:0]     stop_pc,
    input  logic [PC_W-1:0]     cpu_pc,
    output logic                cpu_en,
    output logic [RF_IDX_W-1:0] reg_sel,
    input  logic [DATA_W-1:0]   reg_data,
    sccomp_run_ctrl_if.master   dump,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          cause,
    output logic [31:0]         cycle_cnt
);

    state_t      state_reg;
    cause_t      cause_reg;
    logic        first_reg;
    logic [31:0] run_cnt_reg;
    logic [31:0] cycle_cnt_reg;

    logic hit;
    logic tmo;
    logic stop_run;
    logic dump_start;
    logic beat_ack;
    logic dump_done;

    // The first RUN cycle ignores the breakpoint so a resume from it advances.
    assign hit        = stop_pc_en && (cpu_pc == stop_pc) && !first_reg;
    assign tmo        = (MAX_CYCLES != 0) && (run_cnt_reg == 32'(MAX_CYCLES));
    assign stop_run   = hit || halt_req || tmo;
    assign dump_start = (state_reg == ST_RUN) && stop_run;

    always_comb begin
        cpu_en = 1'b0;
        if (state_reg == ST_STEP)
            cpu_en = 1'b1;
        else if (state_reg == ST_RUN)
            cpu_en = !stop_run;
    end

    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_STEP) ||
                       (state_reg == ST_DUMP_SEL) || (state_reg == ST_DUMP_OUT);
    assign halted    = (state_reg == ST_DONE);
    assign cause     = cause_reg;
    assign cycle_cnt = cycle_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            cause_reg     <= CAUSE_NONE;
            first_reg     <= 1'b0;
            run_cnt_reg   <= '0;
            cycle_cnt_reg <= '0;
        end else begin
            if (cpu_en)
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start || step) begin
                        state_reg   <= start ? ST_RUN : ST_STEP;
                        cause_reg   <= CAUSE_NONE;
                        first_reg   <= 1'b1;
                        run_cnt_reg <= '0;
                    end
                end
                ST_RUN: begin
                    first_reg <= 1'b0;
                    if (stop_run) begin
                        state_reg <= ST_DUMP_SEL;
                        cause_reg <= hit ? CAUSE_PC : (halt_req ? CAUSE_HALT : CAUSE_TMO);
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 32'd1;
                    end
                end
                ST_STEP:     state_reg <= ST_IDLE;
                ST_DUMP_SEL: state_reg <= ST_DUMP_OUT;
                ST_DUMP_OUT: begin
                    if (dump_done)
                        state_reg <= ST_DONE;
                    else if (beat_ack)
                        state_reg <= ST_DUMP_SEL;
                end
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    sccomp_reg_dumper #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_dumper (
        .clk      (clk),
        .rstn     (rstn),
        .start    (dump_start),
        .beat_ack (beat_ack),
        .done     (dump_done),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .dump     (dump)
    );

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// Directed-sequence bench for sccomp_run_ctrl with a PC-stepping CPU stand-in
// and a randomly filled register file as the reference.
module tb_sccomp_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        step;
    logic        halt_req;
    logic        stop_pc_en;
    logic [31:0] stop_pc;
    logic [31:0] cpu_pc;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        busy;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] cycle_cnt;

    logic [31:0] rf [32];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cyc;
    int          nbeats;

    always #5 clk = ~clk;

    sccomp_run_ctrl_if #(.DATA_W(32)) dif ();

    sccomp_run_ctrl #(
        .PC_W       (32),
        .DATA_W     (32),
        .NREG       (32),
        .MAX_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .step       (step),
        .halt_req   (halt_req),
        .stop_pc_en (stop_pc_en),
        .stop_pc    (stop_pc),
        .cpu_pc     (cpu_pc),
        .cpu_en     (cpu_en),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump       (dif),
        .busy       (busy),
        .halted     (halted),
        .cause      (cause),
        .cycle_cnt  (cycle_cnt)
    );

    // CPU stand-in: PC advances by one instruction per enabled cycle.
    assign reg_data = rf[reg_sel];
    always @(posedge clk or negedge rstn) begin
        if (!rstn)
            cpu_pc <= 32'h0;
        else if (cpu_en)
            cpu_pc <= cpu_pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cpu_en"},    cpu_en, 0);
        chk({tag, "_reg_sel"},   reg_sel, 0);
        chk({tag, "_valid"},     dif.dump_valid, 0);
        chk({tag, "_idx"},       dif.dump_idx, 0);
        chk({tag, "_data"},      dif.dump_data, 0);
        chk({tag, "_last"},      dif.dump_last, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_halted"},    halted, 0);
        chk({tag, "_cause"},     cause, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_cyc = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows a run through to DONE, checking every dump beat against the
    // register file. mode: 0 ready high, 1 ready toggling, 2 ready random.
    task automatic run_collect(input int mode, input logic [31:0] halt_at,
                               input int abort_idx, output int nb);
        logic        prev_hold;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        logic        rdy;
        int          cyc;
        nb = 0;
        prev_hold = 1'b0;
        pd = '0;
        pi = '0;
        pl = 1'b0;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            halt_req = (halt_at != 0) && (cpu_pc == halt_at);
            if (prev_hold) begin
                chk("hold_valid", dif.dump_valid, 1);
                chk("hold_data",  dif.dump_data, pd);
                chk("hold_idx",   dif.dump_idx, pi);
                chk("hold_last",  dif.dump_last, pl);
            end
            if (dif.dump_valid && abort_idx >= 0 && int'(dif.dump_idx) == abort_idx) begin
                halt_req = 1'b0;
                rstn = 1'b0;
                #1;
                check_zero("async_rst");
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dif.dump_ready = rdy;
            if (dif.dump_valid && rdy) begin
                if (nb >= 32) begin
                    chk("extra_beat", dif.dump_valid, 0);
                end else begin
                    chk("beat_idx",  dif.dump_idx, nb);
                    chk("beat_data", dif.dump_data, (nb == 0) ? 32'h0 : rf[nb]);
                    chk("beat_last", dif.dump_last, (nb == 31) ? 1 : 0);
                    $display("beat idx=%0d data=0x%08h last=%0b", dif.dump_idx, dif.dump_data, dif.dump_last);
                end
                nb++;
                prev_hold = 1'b0;
            end else if (dif.dump_valid) begin
                prev_hold = 1'b1;
                pd = dif.dump_data;
                pi = dif.dump_idx;
                pl = dif.dump_last;
            end else begin
                prev_hold = 1'b0;
            end
        end
        halt_req = 1'b0;
        dif.dump_ready = 1'b0;
        chk("halted_reached", halted, 1);
    endtask

    task automatic check_stop(input string tag, input int nb, input logic [1:0] exp_cause,
                              input logic [31:0] exp_pc);
        chk({tag, "_beats"},     nb, 32);
        chk({tag, "_cause"},     cause, exp_cause);
        chk({tag, "_pc"},        cpu_pc, exp_pc);
        chk({tag, "_cycle_cnt"}, cycle_cnt, exp_cyc);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_cpu_en"},    cpu_en, 0);
        $display("stop %s cause=%0d pc=0x%0h cycle_cnt=%0d", tag, cause, cpu_pc, cycle_cnt);
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        stop_pc_en = 1'b0;
        stop_pc = 32'h0;
        dif.dump_ready = 1'b0;
        exp_cyc = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;

        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rstn = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

        // halt_req has no effect while idle
        halt_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_halt_busy", busy, 0);
        chk("idle_halt_en",   cpu_en, 0);
        halt_req = 1'b0;
        $display("idle halt_req ignored busy=%0b", busy);

        // single step from IDLE
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_en", cpu_en, 1);
        @(negedge clk);
        chk("step_pc",    cpu_pc, 32'h4);
        chk("step_busy",  busy, 0);
        chk("step_en_off", cpu_en, 0);
        chk("step_cycles", cycle_cnt, 1);
        $display("step pc=0x%0h cycle_cnt=%0d", cpu_pc, cycle_cnt);

        // breakpoint run, ready high
        do_reset();
        stop_pc_en = 1'b1;
        stop_pc = 32'h28;
        pulse_start();
        run_collect(0, 32'h0, -1, nbeats);
        exp_cyc = 32'h28 / 4;
        check_stop("bp", nbeats, 2'd1, 32'h28);

        // breakpoint run, ready toggling
        do_reset();
        pulse_start();
        run_collect(1, 32'h0, -1, nbeats);
        exp_cyc = 32'h28 / 4;
        check_stop("bp_toggle", nbeats, 2'd1, 32'h28);

        // resume from the breakpoint PC, then external halt two instructions on
        pulse_start();
        chk("resume_cause_clr", cause, 0);
        chk("resume_busy",      busy, 1);
        run_collect(2, 32'h30, -1, nbeats);
        exp_cyc = exp_cyc + (32'h30 - 32'h28) / 4;
        check_stop("resume_halt", nbeats, 2'd2, 32'h30);

        // breakpoint and halt in the same cycle: breakpoint wins
        do_reset();
        pulse_start();
        run_collect(2, 32'h28, -1, nbeats);
        exp_cyc = 32'h28 / 4;
        check_stop("bp_and_halt", nbeats, 2'd1, 32'h28);

        // start+step together picks RUN; then the cycle budget expires
        do_reset();
        stop_pc_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        step = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step = 1'b0;
        chk("both_busy", busy, 1);
        chk("both_en",   cpu_en, 1);
        @(negedge clk);
        chk("both_run_en", cpu_en, 1);
        chk("both_run_pc", cpu_pc, 32'h4);
        run_collect(0, 32'h0, -1, nbeats);
        exp_cyc = 32'd1000;
        check_stop("timeout", nbeats, 2'd3, 32'hFA0);

        // reset while beat 7 is on the bus, then a clean rerun
        do_reset();
        stop_pc_en = 1'b1;
        stop_pc = 32'h28;
        pulse_start();
        run_collect(0, 32'h0, 7, nbeats);
        @(negedge clk);
        rstn = 1'b1;
        exp_cyc = 32'd0;
        @(negedge clk);
        chk("post_abort_busy",   busy, 0);
        chk("post_abort_halted", halted, 0);
        pulse_start();
        run_collect(0, 32'h0, -1, nbeats);
        exp_cyc = 32'h28 / 4;
        check_stop("rerun", nbeats, 2'd1, 32'h28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
